// File: rtl/cp0_timer_intc.sv
// CP0 timekeeping and interrupt aggregation: prescaled Count/Compare timer with
// sticky TI, Wired-bounded Random index, hw_int synchroniser, registered int_req.
module cp0_timer_intc #(
    parameter int NUM_HW_INT  = 6,
    parameter int CNT_DIV     = 2,
    parameter int TLB_ENTRIES = 32,
    parameter int SYNC_STAGES = 2,
    localparam int RW         = $clog2(TLB_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [2:0]            wr_sel,
    input  logic [31:0]           wr_data,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic [1:0]            sw_ip,
    input  logic                  status_ie,
    input  logic                  status_exl,
    input  logic                  status_erl,
    input  logic [7:0]            status_im,
    output logic [31:0]           count,
    output logic [31:0]           compare,
    output logic [RW-1:0]         random,
    output logic [RW-1:0]         wired,
    output logic                  cause_ti,
    output logic [7:0]            cause_ip,
    output logic                  int_req
);
    localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

    logic [PW-1:0]   presc_q, presc_d;
    logic [31:0]     count_q, count_d;
    logic [31:0]     compare_q, compare_d;
    logic            ti_q, ti_d;
    logic            match_q, match_d;
    logic [RW-1:0]   random_q, random_d;
    logic [RW-1:0]   wired_q, wired_d;
    logic            int_req_q, int_req_d;
    logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] sync_q, sync_d;

    logic       wr_dec, wr_wired, wr_count, wr_compare;
    logic       tick, match;
    logic [5:0] hw_pad;

    assign wr_dec     = wr_en && (wr_sel == 3'd0);
    assign wr_wired   = wr_dec && (wr_addr == 5'd6);
    assign wr_count   = wr_dec && (wr_addr == 5'd9);
    assign wr_compare = wr_dec && (wr_addr == 5'd11);

    assign tick  = (presc_q == PW'(CNT_DIV - 1));
    assign match = (count_q == compare_q);

    always_comb begin
        presc_d   = tick ? '0 : presc_q + PW'(1);
        count_d   = tick ? count_q + 32'd1 : count_q;
        // A Count write restarts the prescaler so the next tick is a full period away
        if (wr_count) begin
            presc_d = '0;
            count_d = wr_data;
        end
        compare_d = wr_compare ? wr_data : compare_q;
        match_d   = match;
        ti_d      = ti_q | (match & ~match_q);
        if (wr_compare)
            ti_d = 1'b0;
    end

    // wired is RW bits wide, so an out-of-range Wired write truncates and can
    // never reach TLB_ENTRIES; only the equality and zero wraps remain.
    always_comb begin
        wired_d  = wired_q;
        random_d = random_q - RW'(1);
        if (random_q == wired_q || random_q == '0)
            random_d = RW'(TLB_ENTRIES - 1);
        if (wr_wired) begin
            wired_d  = wr_data[RW-1:0];
            random_d = RW'(TLB_ENTRIES - 1);
        end
    end

    always_comb begin
        sync_d[0] = hw_int;
        for (int s = 1; s < SYNC_STAGES; s++)
            sync_d[s] = sync_q[s-1];
    end

    always_comb begin
        hw_pad = '0;
        hw_pad[NUM_HW_INT-1:0] = sync_q[SYNC_STAGES-1];
    end

    // IP7 is shared between the sixth hardware line and the timer
    assign cause_ip  = {hw_pad[5] | ti_q, hw_pad[4:0], sw_ip};
    assign int_req_d = status_ie & ~status_exl & ~status_erl & (|(cause_ip & status_im));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
            match_q   <= 1'b1;
            random_q  <= RW'(TLB_ENTRIES - 1);
            wired_q   <= '0;
            sync_q    <= '0;
            int_req_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            match_q   <= match_d;
            random_q  <= random_d;
            wired_q   <= wired_d;
            sync_q    <= sync_d;
            int_req_q <= int_req_d;
        end
    end

    assign count    = count_q;
    assign compare  = compare_q;
    assign random   = random_q;
    assign wired    = wired_q;
    assign cause_ti = ti_q;
    assign int_req  = int_req_q;
endmodule

// File: tb/tb_cp0_timer_intc.sv
// Bench for cp0_timer_intc: two instances (CNT_DIV=2 and CNT_DIV=1) on shared
// inputs, checked each cycle against an arithmetic model plus directed literals.
module tb_cp0_timer_intc;
    localparam int TLB  = 32;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic [5:0]  hw_int;
    logic [1:0]  sw_ip;
    logic        status_ie, status_exl, status_erl;
    logic [7:0]  status_im;

    logic [31:0] a_count, a_compare, b_count, b_compare;
    logic [4:0]  a_random, a_wired, b_random, b_wired;
    logic        a_ti, a_int_req, b_ti, b_int_req;
    logic [7:0]  a_ip, b_ip;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cp0_timer_intc #(.NUM_HW_INT(6), .CNT_DIV(2), .TLB_ENTRIES(TLB), .SYNC_STAGES(SYNC)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_data(wr_data), .hw_int(hw_int), .sw_ip(sw_ip), .status_ie(status_ie),
        .status_exl(status_exl), .status_erl(status_erl), .status_im(status_im),
        .count(a_count), .compare(a_compare), .random(a_random), .wired(a_wired),
        .cause_ti(a_ti), .cause_ip(a_ip), .int_req(a_int_req));

    cp0_timer_intc #(.NUM_HW_INT(6), .CNT_DIV(1), .TLB_ENTRIES(TLB), .SYNC_STAGES(SYNC)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_data(wr_data), .hw_int(hw_int), .sw_ip(sw_ip), .status_ie(status_ie),
        .status_exl(status_exl), .status_erl(status_erl), .status_im(status_im),
        .count(b_count), .compare(b_compare), .random(b_random), .wired(b_wired),
        .cause_ti(b_ti), .cause_ip(b_ip), .int_req(b_int_req));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: count is the last written value plus elapsed cycles / divider.
    int          div [2] = '{2, 1};
    logic [31:0] m_base [2];
    int          m_n [2];
    logic [31:0] m_cmp [2];
    logic        m_ti [2];
    logic        m_prev_eq [2];
    logic        m_irq [2];
    logic [4:0]  m_rand, m_wired;
    logic [5:0]  m_hist [SYNC];

    function automatic logic [31:0] m_count(input int k);
        return m_base[k] + 32'(m_n[k] / div[k]);
    endfunction

    function automatic logic [7:0] m_ip(input int k);
        logic [5:0] s;
        s = m_hist[SYNC-1];
        return {s[5] | m_ti[k], s[4:0], sw_ip};
    endfunction

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("a_count",   a_count,          m_count(0));
            chk("b_count",   b_count,          m_count(1));
            chk("a_compare", a_compare,        m_cmp[0]);
            chk("b_compare", b_compare,        m_cmp[1]);
            chk("a_ti",      32'(a_ti),        32'(m_ti[0]));
            chk("b_ti",      32'(b_ti),        32'(m_ti[1]));
            chk("a_ip",      32'(a_ip),        32'(m_ip(0)));
            chk("b_ip",      32'(b_ip),        32'(m_ip(1)));
            chk("a_int_req", 32'(a_int_req),   32'(m_irq[0]));
            chk("b_int_req", 32'(b_int_req),   32'(m_irq[1]));
            chk("a_random",  32'(a_random),    32'(m_rand));
            chk("b_random",  32'(b_random),    32'(m_rand));
            chk("a_wired",   32'(a_wired),     32'(m_wired));
            chk("b_wired",   32'(b_wired),     32'(m_wired));
        end
        // advance the model to the state after the coming rising edge
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_base[k] = '0; m_n[k] = 0; m_cmp[k] = '0;
                m_ti[k] = 1'b0; m_prev_eq[k] = 1'b1; m_irq[k] = 1'b0;
            end
            m_rand = 5'(TLB - 1); m_wired = '0;
            for (int j = 0; j < SYNC; j++) m_hist[j] = '0;
        end else begin
            logic wsel;
            wsel = wr_en && wr_sel == 3'd0;
            for (int k = 0; k < 2; k++) begin
                logic eq;
                eq = (m_count(k) == m_cmp[k]);
                m_irq[k] = status_ie && !status_exl && !status_erl && |(m_ip(k) & status_im);
                if (wsel && wr_addr == 5'd11) m_ti[k] = 1'b0;
                else if (eq && !m_prev_eq[k]) m_ti[k] = 1'b1;
                m_prev_eq[k] = eq;
                if (wsel && wr_addr == 5'd9) begin
                    m_base[k] = wr_data; m_n[k] = 0;
                end else m_n[k]++;
                if (wsel && wr_addr == 5'd11) m_cmp[k] = wr_data;
            end
            if (wsel && wr_addr == 5'd6) begin
                m_wired = wr_data[4:0]; m_rand = 5'(TLB - 1);
            end else if (m_rand == m_wired || m_rand == 0) m_rand = 5'(TLB - 1);
            else m_rand = m_rand - 5'd1;
            for (int j = SYNC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = hw_int;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_sel = 3'd0; wr_data = d;
        step(1);
        wr_en = 1'b0;
    endtask

    initial begin
        logic [4:0] seq [6] = '{5'd31, 5'd30, 5'd29, 5'd28, 5'd31, 5'd30};
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_sel = '0; wr_data = '0;
        hw_int = '0; sw_ip = '0; status_ie = 1'b0; status_exl = 1'b0;
        status_erl = 1'b0; status_im = '0;
        step(3);
        rst = 1'b0; chk_en = 1'b1;
        chk("rst_count", a_count, 32'd0);
        chk("rst_ti", 32'(a_ti), 32'd0);
        chk("rst_random", 32'(a_random), 32'd31);
        status_ie = 1'b1; status_im = 8'h80;
        step(10);
        chk("cnt10_count", a_count, 32'd5);
        chk("cnt10_random", 32'(a_random), 32'd21);

        // timer: Compare=8 while count is 3
        wr(5'd9, 32'd3);
        wr(5'd11, 32'd8);
        step(9);
        chk("ti_at8_count", a_count, 32'd8);
        chk("ti_at8_pre", 32'(a_ti), 32'd0);
        step(1);
        chk("ti_set", 32'(a_ti), 32'd1);
        chk("irq_lag", 32'(a_int_req), 32'd0);
        step(1);
        chk("irq_set", 32'(a_int_req), 32'd1);
        step(22);
        chk("ti_at20_count", a_count, 32'd20);
        chk("ti_sticky", 32'(a_ti), 32'd1);
        wr(5'd11, 32'd100);
        chk("ti_clr", 32'(a_ti), 32'd0);
        step(1);
        chk("irq_clr", 32'(a_int_req), 32'd0);

        // 32-bit wrap onto compare=0
        wr(5'd11, 32'd0);
        wr(5'd9, 32'hFFFF_FFFF);
        chk("wrap_b_ff", b_count, 32'hFFFF_FFFF);
        step(1);
        chk("wrap_b_zero", b_count, 32'd0);
        chk("wrap_b_ti_pre", 32'(b_ti), 32'd0);
        chk("wrap_a_hold", a_count, 32'hFFFF_FFFF);
        step(1);
        chk("wrap_b_ti", 32'(b_ti), 32'd1);
        chk("wrap_a_zero", a_count, 32'd0);

        // Random bounded by Wired
        wr(5'd6, 32'd28);
        chk("wired28", 32'(a_wired), 32'd28);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step(1);
            chk("rand_w28", 32'(a_random), 32'(seq[i]));
        end
        wr(5'd6, 32'd40);
        chk("wired40", 32'(a_wired), 32'd8);
        chk("rand_w40", 32'(a_random), 32'd31);
        step(1);
        chk("rand_w40_n", 32'(a_random), 32'd30);
        wr(5'd1, 32'd5);
        chk("rand_ro", 32'(a_random), 32'd29);
        step(1);
        chk("rand_ro_n", 32'(a_random), 32'd28);

        // hardware interrupt path
        status_im = 8'h10;
        hw_int = 6'b000100;
        step(1);
        chk("hw_ip_1", 32'(a_ip[4]), 32'd0);
        step(1);
        chk("hw_ip_2", 32'(a_ip[4]), 32'd1);
        chk("hw_irq_2", 32'(a_int_req), 32'd0);
        step(1);
        chk("hw_irq_3", 32'(a_int_req), 32'd1);
        status_exl = 1'b1;
        step(1);
        chk("hw_exl", 32'(a_int_req), 32'd0);
        hw_int = '0;
        step(1);
        chk("hw_off_1", 32'(a_ip[4]), 32'd1);
        step(1);
        chk("hw_off_2", 32'(a_ip[4]), 32'd0);
        status_exl = 1'b0;

        // reset with TI pending and hw_int[0] asserted
        status_im = 8'hFF;
        hw_int = 6'b000001;
        step(3);
        chk("pre_rst_ip", 32'(a_ip), 32'h84);
        chk("pre_rst_irq", 32'(a_int_req), 32'd1);
        rst = 1'b1;
        step(1);
        chk("mid_rst_ti", 32'(a_ti), 32'd0);
        chk("mid_rst_ip", 32'(a_ip), 32'd0);
        chk("mid_rst_irq", 32'(a_int_req), 32'd0);
        rst = 1'b0;
        step(1);
        chk("post_rst_1", 32'(a_ip[2]), 32'd0);
        step(1);
        chk("post_rst_2", 32'(a_ip[2]), 32'd1);

        sw_ip = 2'b10;
        #1;
        chk("sw_ip", 32'(a_ip[1:0]), 32'd2);
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
